// File: rtl/logic_axi4_stream_fifo_sync_pkg.sv
// Shared types and sizing helpers for the single-clock AXI4-Stream FIFO.
// Contents: target_t (memory implementation selector), ptr_width(), level_width().
package logic_axi4_stream_fifo_sync_pkg;

  // Memory implementation selector
  typedef enum logic [1:0] {
    TARGET_GENERIC,
    TARGET_XILINX,
    TARGET_INTEL
  } target_t;

  // Pointer width for a ring of cap entries
  function automatic int unsigned ptr_width(input int unsigned cap);
    return (cap > 1) ? $clog2(cap) : 1;
  endfunction

  // Width able to hold 0..cap inclusive
  function automatic int unsigned level_width(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/logic_axi4_stream_fifo_sync_if.sv
// AXI4-Stream handshake bundle.
// Signals: tvalid, tready, tlast, tdata[WIDTH].
// Modports: master drives valid/last/data, slave drives ready.
interface logic_axi4_stream_fifo_sync_if #(
  parameter int unsigned WIDTH = 1
);
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/logic_axi4_stream_fifo_sync_memory.sv
// Simple dual-port RAM with one-cycle registered read.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
//        rd_data registered read data, held while rd_en is low.
module logic_axi4_stream_fifo_sync_memory
  import logic_axi4_stream_fifo_sync_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ADDR_W = 3,
  parameter target_t     TARGET = TARGET_GENERIC
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  if (TARGET != TARGET_GENERIC) begin : g_vendor
    // Vendor flow: steer inference onto block RAM
    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end else begin : g_generic
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/logic_axi4_stream_fifo_sync.sv
// Single-clock AXI4-Stream FIFO with fill level, threshold flags, sync flush
// and optional store-and-forward packet mode.
// Ports: aclk, areset (async, active-high), flush (sync clear),
//        rx (stream in, slave), tx (stream out, master),
//        level (words held incl. output stages), almost_full, almost_empty,
//        packet_overflow (one-cycle pulse on forced commit).
// Datapath: RAM -> registered RAM read (stage p) -> output register (tx).
`ifndef LOGIC_CONFIG_TARGET
`define LOGIC_CONFIG_TARGET TARGET_GENERIC
`endif

module logic_axi4_stream_fifo_sync
  import logic_axi4_stream_fifo_sync_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned CAPACITY     = 256,
  parameter bit          PACKET_MODE  = 1'b0,
  parameter int unsigned ALMOST_FULL  = CAPACITY - 1,
  parameter int unsigned ALMOST_EMPTY = 1,
  parameter target_t     TARGET       = `LOGIC_CONFIG_TARGET
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             flush,
  logic_axi4_stream_fifo_sync_if.slave     rx,
  logic_axi4_stream_fifo_sync_if.master    tx,
  output logic [$clog2(CAPACITY+1)-1:0]    level,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic                             packet_overflow
);

  localparam int unsigned PTR_W   = ptr_width(CAPACITY);
  localparam int unsigned LEVEL_W = level_width(CAPACITY);
  localparam int unsigned MEM_W   = WIDTH + 1;

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] mem_cnt;      // words in RAM not yet fetched
  logic [LEVEL_W-1:0] cmt_cnt;      // committed subset of mem_cnt
  logic               p_valid;      // RAM read register holds a word
  logic               cut_through;  // overflowed packet still arriving
  logic [MEM_W-1:0]   rd_data;

  logic               wr_c, rd_c, load_c, fetch_c, ovf_c, commit_c;
  logic [LEVEL_W-1:0] level_nxt_c, mem_cnt_nxt_c, cmt_cnt_nxt_c;

  // Ring pointer increment, wraps at CAPACITY-1 for any capacity
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == CAPACITY - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes, pipeline advance and next-state counters
  always_comb begin
    wr_c     = rx.tvalid && rx.tready && !flush;
    rd_c     = tx.tvalid && tx.tready && !flush;
    load_c   = p_valid && (!tx.tvalid || tx.tready);
    fetch_c  = !flush && ((PACKET_MODE ? cmt_cnt : mem_cnt) != '0) && (!p_valid || load_c);
    // Full of one uncommitted packet: nothing could ever drain, so release it
    ovf_c    = PACKET_MODE && !flush && (32'(mem_cnt) == CAPACITY) && (cmt_cnt == '0);
    commit_c = (wr_c && (rx.tlast || cut_through)) || ovf_c;

    level_nxt_c   = level + LEVEL_W'(wr_c) - LEVEL_W'(rd_c);
    mem_cnt_nxt_c = mem_cnt + LEVEL_W'(wr_c) - LEVEL_W'(fetch_c);
    if (!PACKET_MODE || commit_c) cmt_cnt_nxt_c = mem_cnt_nxt_c;
    else                          cmt_cnt_nxt_c = cmt_cnt - LEVEL_W'(fetch_c);

    if (flush) begin
      level_nxt_c   = '0;
      mem_cnt_nxt_c = '0;
      cmt_cnt_nxt_c = '0;
    end
  end

  // State, flags and output stage
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      mem_cnt         <= '0;
      cmt_cnt         <= '0;
      p_valid         <= 1'b0;
      cut_through     <= 1'b0;
      level           <= '0;
      almost_full     <= 1'b0;
      almost_empty    <= 1'b1;
      packet_overflow <= 1'b0;
      rx.tready       <= 1'b0;
      tx.tvalid       <= 1'b0;
      tx.tlast        <= 1'b0;
      tx.tdata        <= '0;
    end else begin
      level           <= level_nxt_c;
      mem_cnt         <= mem_cnt_nxt_c;
      cmt_cnt         <= cmt_cnt_nxt_c;
      rx.tready       <= 32'(level_nxt_c) < CAPACITY;
      almost_full     <= 32'(level_nxt_c) >= ALMOST_FULL;
      almost_empty    <= 32'(level_nxt_c) <= ALMOST_EMPTY;
      packet_overflow <= ovf_c;
      if (flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        p_valid     <= 1'b0;
        cut_through <= 1'b0;
        tx.tvalid   <= 1'b0;
        tx.tlast    <= 1'b0;
        tx.tdata    <= '0;
      end else begin
        if (wr_c)    wr_ptr <= ptr_inc(wr_ptr);
        if (fetch_c) rd_ptr <= ptr_inc(rd_ptr);

        if (fetch_c)     p_valid <= 1'b1;
        else if (load_c) p_valid <= 1'b0;

        if (ovf_c)                  cut_through <= 1'b1;
        else if (wr_c && rx.tlast)  cut_through <= 1'b0;

        // Output register only moves when empty or being consumed
        if (load_c) begin
          tx.tvalid             <= 1'b1;
          {tx.tlast, tx.tdata}  <= rd_data;
        end else if (rd_c) begin
          tx.tvalid <= 1'b0;
        end
      end
    end
  end

  logic_axi4_stream_fifo_sync_memory #(
    .DEPTH  (CAPACITY),
    .DATA_W (MEM_W),
    .ADDR_W (PTR_W),
    .TARGET (TARGET)
  ) u_memory (
    .clk     (aclk),
    .wr_en   (wr_c),
    .wr_addr (wr_ptr),
    .wr_data ({rx.tlast, rx.tdata}),
    .rd_en   (fetch_c),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_logic_axi4_stream_fifo_sync.sv
// Directed bench for logic_axi4_stream_fifo_sync: one stream instance and one
// packet-mode instance, both CAPACITY=8, WIDTH=8. Inputs are driven and outputs
// sampled on the falling edge.
module tb_logic_axi4_stream_fifo_sync;

  localparam int unsigned W   = 8;
  localparam int unsigned CAP = 8;
  localparam int unsigned LW  = $clog2(CAP + 1);

  logic          aclk;
  logic          areset;
  logic          s_flush, p_flush;
  logic [LW-1:0] s_level, p_level;
  logic          s_af, s_ae, s_ovf;
  logic          p_af, p_ae, p_ovf;

  int n_cmp;
  int n_err;

  logic_axi4_stream_fifo_sync_if #(.WIDTH(W)) s_rx ();
  logic_axi4_stream_fifo_sync_if #(.WIDTH(W)) s_tx ();
  logic_axi4_stream_fifo_sync_if #(.WIDTH(W)) p_rx ();
  logic_axi4_stream_fifo_sync_if #(.WIDTH(W)) p_tx ();

  logic_axi4_stream_fifo_sync #(
    .WIDTH(W), .CAPACITY(CAP), .PACKET_MODE(1'b0)
  ) dut_s (
    .aclk            (aclk),
    .areset          (areset),
    .flush           (s_flush),
    .rx              (s_rx),
    .tx              (s_tx),
    .level           (s_level),
    .almost_full     (s_af),
    .almost_empty    (s_ae),
    .packet_overflow (s_ovf)
  );

  logic_axi4_stream_fifo_sync #(
    .WIDTH(W), .CAPACITY(CAP), .PACKET_MODE(1'b1)
  ) dut_p (
    .aclk            (aclk),
    .areset          (areset),
    .flush           (p_flush),
    .rx              (p_rx),
    .tx              (p_tx),
    .level           (p_level),
    .almost_full     (p_af),
    .almost_empty    (p_ae),
    .packet_overflow (p_ovf)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int sent;
  int recv;
  int gaps;
  int ovf_seen;

  initial begin
    n_cmp = 0;
    n_err = 0;
    areset = 1'b1;
    s_flush = 1'b0;
    p_flush = 1'b0;
    s_rx.tvalid = 1'b0; s_rx.tlast = 1'b0; s_rx.tdata = '0; s_tx.tready = 1'b0;
    p_rx.tvalid = 1'b0; p_rx.tlast = 1'b0; p_rx.tdata = '0; p_tx.tready = 1'b0;

    // Reset values
    repeat (3) @(negedge aclk);
    check("rst_rx_tready", 32'(s_rx.tready), 0);
    check("rst_tx_tvalid", 32'(s_tx.tvalid), 0);
    check("rst_tx_tdata", 32'(s_tx.tdata), 0);
    check("rst_level", 32'(s_level), 0);
    check("rst_almost_empty", 32'(s_ae), 1);
    check("rst_almost_full", 32'(s_af), 0);
    check("rst_pkt_overflow", 32'(p_ovf), 0);
    areset = 1'b0;
    #1 check("rel_rx_tready_before_edge", 32'(s_rx.tready), 0);
    @(negedge aclk);
    check("rel_rx_tready", 32'(s_rx.tready), 1);
    check("rel_p_rx_tready", 32'(p_rx.tready), 1);

    // Latency and output hold: accepted at edge k, visible after k+2
    s_rx.tvalid = 1'b1; s_rx.tdata = 8'h3C; s_rx.tlast = 1'b1;
    @(negedge aclk);
    s_rx.tvalid = 1'b0; s_rx.tlast = 1'b0;
    check("lat_k", 32'(s_tx.tvalid), 0);
    check("lat_level", 32'(s_level), 1);
    @(negedge aclk);
    check("lat_k1", 32'(s_tx.tvalid), 0);
    @(negedge aclk);
    check("lat_k2_valid", 32'(s_tx.tvalid), 1);
    check("lat_k2_data", 32'(s_tx.tdata), 32'h3C);
    check("lat_k2_last", 32'(s_tx.tlast), 1);
    @(negedge aclk);
    check("hold_valid", 32'(s_tx.tvalid), 1);
    check("hold_data", 32'(s_tx.tdata), 32'h3C);
    s_tx.tready = 1'b1;
    @(negedge aclk);
    check("lat_drained_valid", 32'(s_tx.tvalid), 0);
    check("lat_drained_level", 32'(s_level), 0);
    s_tx.tready = 1'b0;

    // Fill: offer 0..9 with tx stalled, expect 8 accepted
    sent = 0;
    for (int c = 0; c < 14; c++) begin
      if (sent < 10) begin
        s_rx.tvalid = 1'b1;
        s_rx.tdata  = 8'(sent);
        if (s_rx.tready) sent++;
      end else begin
        s_rx.tvalid = 1'b0;
      end
      @(negedge aclk);
    end
    s_rx.tvalid = 1'b0;
    check("fill_accepted", 32'(sent), 8);
    check("fill_rx_tready", 32'(s_rx.tready), 0);
    check("fill_level", 32'(s_level), 8);
    check("fill_almost_full", 32'(s_af), 1);
    check("fill_almost_empty", 32'(s_ae), 0);
    check("fill_head_data", 32'(s_tx.tdata), 0);

    // Full boundary then drain: read + blocked write in the same cycle
    s_tx.tready = 1'b1;
    recv = 0;
    gaps = 0;
    for (int c = 0; c < 30 && recv < 8; c++) begin
      if (c == 0) begin
        s_rx.tvalid = 1'b1;
        s_rx.tdata  = 8'hAA;
      end
      if (s_tx.tvalid) begin
        check("drain_data", 32'(s_tx.tdata), 32'(recv));
        recv++;
      end else begin
        gaps++;
      end
      @(negedge aclk);
      if (c == 0) begin
        check("full_rx_tready_next", 32'(s_rx.tready), 1);
        check("full_level_next", 32'(s_level), 7);
        s_rx.tvalid = 1'b0;
      end
    end
    check("drain_count", 32'(recv), 8);
    check("drain_gaps", 32'(gaps), 0);
    check("drain_tvalid_end", 32'(s_tx.tvalid), 0);
    check("drain_level_end", 32'(s_level), 0);
    check("drain_almost_empty", 32'(s_ae), 1);

    // Packet mode: 3-beat packet held back until committed
    p_tx.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_rx.tvalid = 1'b1;
      p_rx.tdata  = 8'(8'h11 * (i + 1));
      p_rx.tlast  = (i == 2);
      @(negedge aclk);
      check("pkt_held", 32'(p_tx.tvalid), 0);
    end
    p_rx.tvalid = 1'b0;
    p_rx.tlast  = 1'b0;
    check("pkt_level", 32'(p_level), 3);
    @(negedge aclk);
    check("pkt_edge1_after_last", 32'(p_tx.tvalid), 0);
    @(negedge aclk);
    check("pkt_edge2_valid", 32'(p_tx.tvalid), 1);
    check("pkt_beat0", 32'(p_tx.tdata), 32'h11);
    check("pkt_beat0_last", 32'(p_tx.tlast), 0);
    @(negedge aclk);
    check("pkt_beat1", 32'(p_tx.tdata), 32'h22);
    @(negedge aclk);
    check("pkt_beat2", 32'(p_tx.tdata), 32'h33);
    check("pkt_beat2_last", 32'(p_tx.tlast), 1);
    @(negedge aclk);
    check("pkt_done_valid", 32'(p_tx.tvalid), 0);
    check("pkt_done_level", 32'(p_level), 0);

    // Packet overflow: 12-beat packet into 8 words
    sent = 0;
    recv = 0;
    ovf_seen = 0;
    for (int c = 0; c < 100 && recv < 12; c++) begin
      if (p_tx.tvalid) begin
        check("ovf_data", 32'(p_tx.tdata), 32'h40 + 32'(recv));
        check("ovf_last", 32'(p_tx.tlast), (recv == 11) ? 1 : 0);
        recv++;
      end
      if (p_ovf) begin
        ovf_seen++;
        check("ovf_pulse_level", 32'(p_level), 8);
      end
      if (sent < 12) begin
        p_rx.tvalid = 1'b1;
        p_rx.tdata  = 8'(8'h40 + sent);
        p_rx.tlast  = (sent == 11);
        if (p_rx.tready) sent++;
      end else begin
        p_rx.tvalid = 1'b0;
        p_rx.tlast  = 1'b0;
      end
      @(negedge aclk);
    end
    p_rx.tvalid = 1'b0;
    p_rx.tlast  = 1'b0;
    check("ovf_recv_count", 32'(recv), 12);
    check("ovf_pulse_count", 32'(ovf_seen), 1);
    check("ovf_level_end", 32'(p_level), 0);

    // Flush at level 5 with simultaneous rx and tx beats
    s_tx.tready = 1'b0;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      if (sent < 5) begin
        s_rx.tvalid = 1'b1;
        s_rx.tdata  = 8'(8'h20 + sent);
        if (s_rx.tready) sent++;
      end else begin
        s_rx.tvalid = 1'b0;
      end
      @(negedge aclk);
    end
    check("pre_flush_level", 32'(s_level), 5);
    check("pre_flush_valid", 32'(s_tx.tvalid), 1);
    s_flush = 1'b1;
    s_rx.tvalid = 1'b1;
    s_rx.tdata  = 8'hEE;
    s_tx.tready = 1'b1;
    @(negedge aclk);
    s_flush = 1'b0;
    s_rx.tvalid = 1'b0;
    check("flush_level", 32'(s_level), 0);
    check("flush_tvalid", 32'(s_tx.tvalid), 0);
    check("flush_rx_tready", 32'(s_rx.tready), 1);
    check("flush_almost_empty", 32'(s_ae), 1);
    repeat (3) @(negedge aclk);
    check("flush_no_stale_valid", 32'(s_tx.tvalid), 0);
    check("flush_no_stale_level", 32'(s_level), 0);

    // Traffic after flush
    s_rx.tvalid = 1'b1;
    s_rx.tdata  = 8'h5A;
    @(negedge aclk);
    s_rx.tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    check("post_flush_valid", 32'(s_tx.tvalid), 1);
    check("post_flush_data", 32'(s_tx.tdata), 32'h5A);
    @(negedge aclk);
    check("post_flush_level", 32'(s_level), 0);

    // Async reset mid-operation
    s_tx.tready = 1'b0;
    s_rx.tvalid = 1'b1;
    s_rx.tdata  = 8'h77;
    repeat (4) @(negedge aclk);
    s_rx.tvalid = 1'b0;
    check("pre_areset_level", 32'(s_level), 4);
    areset = 1'b1;
    #1;
    check("areset_level", 32'(s_level), 0);
    check("areset_rx_tready", 32'(s_rx.tready), 0);
    check("areset_tx_tvalid", 32'(s_tx.tvalid), 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("areset_rel_rx_tready", 32'(s_rx.tready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
